seg7_monitor: RTL

- Reader for a 7-segment bus: samples the active-low segment drive of one digit, filters glitches, and decodes the pattern back to a 4-bit hex value.
- Classifies each accepted change as an up step, a down step, a bad step, or an illegal pattern.
- Sits beside the counter/display path as an on-chip self-check of the displayed count; its outputs feed LEDs or a test bench scoreboard.

---
 rtl/seg7_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/seg7_monitor.sv
// seg7_monitor: synchronises and debounces one active-low 7-segment digit, decodes it
// back to hex and classifies each accepted change as up/down/bad step or illegal pattern.
module seg7_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_in,
  output logic [3:0]       value,
  output logic             value_vld,
  output logic             new_pulse,
  output logic             dir_up,
  output logic             dir_down,
  output logic             step_err,
  output logic             bad_pat,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int                STAB_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [0:0]        TRACK     = 1'b0;
  localparam logic [0:0]        LOCKED    = 1'b1;
  localparam logic [6:0]        BLANK     = 7'h7F;

  // Returns {legal, digit}; patterns are gfedcba, active-low.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [6:0]        sync1_q, sync2_q, cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [0:0]        state_q, state_d;
  logic              have_prev_q, have_prev_d;
  logic [3:0]        value_q, value_d;
  logic              vld_q, vld_d;
  logic              new_q, new_d, up_q, up_d, down_q, down_d;
  logic              step_q, step_d, bad_q, bad_d;
  logic [CNT_W-1:0]  err_q, err_d, err_inc_s;
  logic              accept_s;
  logic [4:0]        dec_s;
  logic [3:0]        delta_s;

  assign dec_s     = decode(cand_q);
  assign delta_s   = dec_s[3:0] - value_q;
  assign err_inc_s = (err_q == {CNT_W{1'b1}}) ? err_q : err_q + CNT_W'(1);

  always_comb begin
    cand_d      = cand_q;
    stab_d      = stab_q;
    state_d     = state_q;
    have_prev_d = have_prev_q;
    value_d     = value_q;
    vld_d       = vld_q;
    err_d       = err_q;
    new_d       = 1'b0;
    up_d        = 1'b0;
    down_d      = 1'b0;
    step_d      = 1'b0;
    bad_d       = 1'b0;
    accept_s    = 1'b0;

    if (sync2_q != cand_q) begin
      cand_d  = sync2_q;
      stab_d  = '0;
      state_d = TRACK;
    end else if (state_q == TRACK && stab_q == STAB_LAST) begin
      state_d  = LOCKED;
      accept_s = 1'b1;
    end else if (state_q == TRACK) begin
      stab_d = stab_q + STAB_W'(1);
    end else begin
      state_d = LOCKED;
    end

    // A blank display breaks the sequence; an equal re-accept is silent.
    if (accept_s) begin
      if (cand_q == BLANK) begin
        have_prev_d = 1'b0;
      end else if (!dec_s[4]) begin
        bad_d = 1'b1;
        err_d = err_inc_s;
      end else if (!have_prev_q) begin
        value_d     = dec_s[3:0];
        vld_d       = 1'b1;
        new_d       = 1'b1;
        have_prev_d = 1'b1;
      end else if (dec_s[3:0] != value_q) begin
        value_d = dec_s[3:0];
        new_d   = 1'b1;
        if (delta_s == 4'h1) begin
          up_d = 1'b1;
        end else if (delta_s == 4'hF) begin
          down_d = 1'b1;
        end else begin
          step_d = 1'b1;
          err_d  = err_inc_s;
        end
      end else begin
        new_d = 1'b0;
      end
    end else begin
      new_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= BLANK;
      sync2_q     <= BLANK;
      cand_q      <= BLANK;
      stab_q      <= '0;
      state_q     <= LOCKED;
      have_prev_q <= 1'b0;
      value_q     <= 4'h0;
      vld_q       <= 1'b0;
      new_q       <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      step_q      <= 1'b0;
      bad_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      sync1_q     <= seg_in;
      sync2_q     <= sync1_q;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      state_q     <= state_d;
      have_prev_q <= have_prev_d;
      value_q     <= value_d;
      vld_q       <= vld_d;
      new_q       <= new_d;
      up_q        <= up_d;
      down_q      <= down_d;
      step_q      <= step_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
    end
  end

  assign value     = value_q;
  assign value_vld = vld_q;
  assign new_pulse = new_q;
  assign dir_up    = up_q;
  assign dir_down  = down_q;
  assign step_err  = step_q;
  assign bad_pat   = bad_q;
  assign err_cnt   = err_q;

endmodule
